cpu_bus_responder: RTL

- Bus-side responder for the cpu6502 core. It decodes the core's addr/wr_en/dout and returns din and ready.
- Contains an internal RAM, a timer/interrupt register block, and an external-ROM handshake with wait states.
- Generates the core's irq and nmi inputs. It sits between the core and the rest of the system, one per CPU.

---
 rtl/cpu_bus_responder_if.sv | 11 +
 rtl/cpu_bus_responder.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/cpu_bus_responder_if.sv
// CPU-side bus between the cpu6502 core and its bus responder.
interface cpu_bus_responder_if;
  logic [15:0] addr;
  logic        wr_en;
  logic [7:0]  dout;
  logic [7:0]  din;
  logic        ready;

  modport master (output addr, output wr_en, output dout, input din, input ready);
  modport slave  (input addr, input wr_en, input dout, output din, output ready);
endinterface

// File: rtl/cpu_bus_responder.sv
// Bus responder for one cpu6502 core: internal RAM, timer/IRQ and NMI registers,
// and a wait-stated read handshake to an external ROM region.
module cpu_bus_responder #(
  parameter int unsigned RAM_AW    = 11,
  parameter logic [15:0] IO_BASE   = 16'hD000,
  parameter logic [15:0] EXT_BASE  = 16'hE000,
  parameter int unsigned NMI_PULSE = 4,
  parameter logic [7:0]  OPEN_BUS  = 8'hFF
) (
  input  logic                     clock,
  input  logic                     reset,
  cpu_bus_responder_if.slave       bus,
  output logic                     irq,
  output logic                     nmi,
  input  logic                     nmi_button,
  output logic                     ext_req,
  output logic [12:0]              ext_addr,
  input  logic                     ext_ack,
  input  logic [7:0]               ext_data
);

  localparam int unsigned RAM_DEPTH = 1 << RAM_AW;
  localparam int unsigned EXT_AW    = 13;
  localparam int unsigned NMI_CW    = 4;
  localparam logic [16:0] RAM_TOP   = 17'(RAM_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  state_t              state, state_nxt;
  logic                ext_req_nxt;
  logic [EXT_AW-1:0]   ext_addr_nxt;
  logic [7:0]          ext_latch, ext_latch_nxt;
  logic [7:0]          din_nxt;

  logic [7:0]  reload_lo, reload_lo_nxt;
  logic [7:0]  reload_hi, reload_hi_nxt;
  logic [2:0]  ctrl, ctrl_nxt;
  logic        pending, pending_nxt;
  logic        reload_due, reload_due_nxt;
  logic [15:0] count, count_nxt;
  logic [7:0]  snap, snap_nxt;
  logic [7:0]  io_rdata;

  logic              sync1, sync2, sync3;
  logic [NMI_CW-1:0] nmi_cnt, nmi_cnt_nxt;
  logic              nmi_trig;

  logic [7:0] ram [RAM_DEPTH];

  // Address decode; RAM has priority over the IO window, IO over the external region
  logic       ram_hit, io_hit, ext_hit, ext_rd, io_wr, io_rd, expire;
  logic [3:0] io_off;

  assign ram_hit = {1'b0, bus.addr} < RAM_TOP;
  assign io_hit  = !ram_hit && (bus.addr[15:4] == IO_BASE[15:4]);
  assign ext_hit = !ram_hit && !io_hit && (bus.addr >= EXT_BASE);
  assign ext_rd  = ext_hit && !bus.wr_en;
  assign io_wr   = io_hit && bus.wr_en;
  assign io_rd   = io_hit && !bus.wr_en;
  assign io_off  = bus.addr[3:0];
  assign expire  = ctrl[0] && (count == 16'd1);

  assign bus.ready = !(ext_rd && (state != S_DONE));

  // External read handshake: next state and registered handshake outputs
  always_comb begin
    state_nxt     = state;
    ext_req_nxt   = ext_req;
    ext_addr_nxt  = ext_addr;
    ext_latch_nxt = ext_latch;
    case (state)
      S_IDLE: if (ext_rd) begin
        state_nxt    = S_REQ;
        ext_req_nxt  = 1'b1;
        ext_addr_nxt = EXT_AW'(bus.addr - EXT_BASE);
      end
      S_REQ: if (ext_ack) begin
        ext_latch_nxt = ext_data;
        ext_req_nxt   = 1'b0;
        state_nxt     = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Timer, status and CPU register writes; a pending set beats a same-edge clear
  always_comb begin
    reload_lo_nxt  = reload_lo;
    reload_hi_nxt  = reload_hi;
    ctrl_nxt       = ctrl;
    pending_nxt    = pending;
    count_nxt      = count;
    snap_nxt       = snap;
    reload_due_nxt = expire && ctrl[2];

    if (reload_due)
      count_nxt = {reload_hi, reload_lo};
    else if (ctrl[0] && (count != 16'd0))
      count_nxt = count - 16'd1;
    if (expire && !ctrl[2])
      ctrl_nxt[0] = 1'b0;

    if (io_wr) begin
      case (io_off)
        4'd0: reload_lo_nxt = bus.dout;
        4'd1: begin
          reload_hi_nxt = bus.dout;
          count_nxt     = {bus.dout, reload_lo};
        end
        4'd2: ctrl_nxt = bus.dout[2:0];
        4'd3: if (bus.dout[0]) pending_nxt = 1'b0;
        default: ;
      endcase
    end
    if (expire)
      pending_nxt = 1'b1;
    if (io_rd && (io_off == 4'd4))
      snap_nxt = count[15:8];
  end

  always_comb begin
    io_rdata = 8'h00;
    case (io_off)
      4'd0: io_rdata = reload_lo;
      4'd1: io_rdata = reload_hi;
      4'd2: io_rdata = {5'b0, ctrl};
      4'd3: io_rdata = {7'b0, pending};
      4'd4: io_rdata = count[7:0];
      4'd5: io_rdata = snap;
      default: io_rdata = 8'h00;
    endcase
  end

  // Read data mux; din holds during an external stall until DONE delivers the latch
  always_comb begin
    din_nxt = OPEN_BUS;
    if (bus.wr_en)     din_nxt = OPEN_BUS;
    else if (ram_hit)  din_nxt = ram[bus.addr[RAM_AW-1:0]];
    else if (io_hit)   din_nxt = io_rdata;
    else if (ext_hit)  din_nxt = (state == S_DONE) ? ext_latch : bus.din;
  end

  // NMI trigger: button rising edge after synchronisation, or any NMI_TRIG write
  always_comb begin
    nmi_trig    = (sync2 && !sync3) || (io_wr && (io_off == 4'd6));
    nmi_cnt_nxt = nmi_cnt;
    if (nmi_trig)
      nmi_cnt_nxt = NMI_CW'(NMI_PULSE);
    else if (nmi_cnt != '0)
      nmi_cnt_nxt = nmi_cnt - NMI_CW'(1);
  end

  always_ff @(posedge clock) begin
    if (bus.wr_en && ram_hit)
      ram[bus.addr[RAM_AW-1:0]] <= bus.dout;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      ext_req    <= 1'b0;
      ext_addr   <= '0;
      ext_latch  <= 8'h00;
      bus.din    <= 8'h00;
      reload_lo  <= 8'h00;
      reload_hi  <= 8'h00;
      ctrl       <= 3'b0;
      pending    <= 1'b0;
      reload_due <= 1'b0;
      count      <= 16'h0000;
      snap       <= 8'h00;
      irq        <= 1'b0;
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      sync3      <= 1'b0;
      nmi_cnt    <= '0;
      nmi        <= 1'b0;
    end else begin
      state      <= state_nxt;
      ext_req    <= ext_req_nxt;
      ext_addr   <= ext_addr_nxt;
      ext_latch  <= ext_latch_nxt;
      bus.din    <= din_nxt;
      reload_lo  <= reload_lo_nxt;
      reload_hi  <= reload_hi_nxt;
      ctrl       <= ctrl_nxt;
      pending    <= pending_nxt;
      reload_due <= reload_due_nxt;
      count      <= count_nxt;
      snap       <= snap_nxt;
      irq        <= pending_nxt && ctrl_nxt[1];
      sync1      <= nmi_button;
      sync2      <= sync1;
      sync3      <= sync2;
      nmi_cnt    <= nmi_cnt_nxt;
      nmi        <= (nmi_cnt_nxt != '0);
    end
  end

endmodule
